button_conditioner: RTL and testbench
=====================================

# button_conditioner

Cleans one raw mechanical push-button input into glitch-free level and single-cycle event pulses for downstream counter/LED logic, which consumes `count_pulse` as a synchronous clock-enable instead of clocking on the raw button. Sits directly between the board pin and the LED counter. It provides metastability synchronization, time-based debounce, press/release edge events and optional hold-to-repeat.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; must be at least 2.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be at least 2.
- `ACTIVE_LOW`, default 0: when 1, `btn_raw` is inverted before synchronization.
- `REPEAT_DELAY`, default 25000000: cycles from `press_pulse` to the first `repeat_pulse`.
- `REPEAT_RATE`, default 5000000: cycles between subsequent `repeat_pulse`s.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `btn_raw`, input, 1: unsynchronized pin.
- `btn_level`, output, 1: debounced pressed state, 1 = pressed.
- `press_pulse`, output, 1: one-cycle pulse on an accepted press.
- `release_pulse`, output, 1: one-cycle pulse on an accepted release.
- `repeat_pulse`, output, 1: one-cycle auto-repeat pulse while held.
- `count_pulse`, output, 1: `press_pulse | repeat_pulse`; this is the counter enable.

## Operation
- **Normalization:** `btn_raw` is XORed with `ACTIVE_LOW`, then passed through the `SYNC_STAGES` flop chain. Call the chain output `s`.
- **FSM states:**
  - IDLE → PRESS_WAIT when `s`=1.
  - PRESS_WAIT → IDLE when `s`=0 (bounce); the counter clears.
  - PRESS_WAIT → HELD when the counter reaches DEBOUNCE_CYCLES-1 with `s` still 1. `press_pulse` is asserted for that one cycle and `btn_level` is set.
  - HELD → REL_WAIT when `s`=0.
  - REL_WAIT → HELD when `s`=1 (bounce; no pulse, counter clears).
  - REL_WAIT → IDLE when the counter reaches DEBOUNCE_CYCLES-1 with `s` still 0. `release_pulse` is asserted and `btn_level` is cleared.
- **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES)`. It increments only in the WAIT states, clears on every state change, and never wraps.
- **Repeat timer:** width `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`. It is loaded on entry to HELD and counts only in HELD.
  - At REPEAT_DELAY it emits `repeat_pulse` and reloads with period REPEAT_RATE.
  - It freezes in REL_WAIT, so a bounce during release neither fires a repeat nor restarts the delay.
- **Pulse exclusivity:** `press_pulse`, `release_pulse` and `repeat_pulse` are mutually exclusive within any cycle.
- **Button held through reset:** after reset deasserts, the press is detected through the normal PRESS_WAIT path and a `press_pulse` is emitted.
- **Reset values:** all outputs 0, FSM = IDLE, all counters 0, synchronizer flops 0 (the normalized inactive level). Reset asserted mid-debounce or mid-hold aborts with no pulse.

## Timing
- **Press latency:** from the first clock edge sampling a stable new `btn_raw` level to `press_pulse` high is exactly SYNC_STAGES + DEBOUNCE_CYCLES edges. Release latency is identical.
- **`btn_level`:** changes on the same edge its pulse asserts.
- **Pulse width:** every pulse is exactly one clk cycle high.
- **Repeat spacing:** the first `repeat_pulse` is REPEAT_DELAY cycles after `press_pulse`, then one every REPEAT_RATE cycles.
- **Glitch rejection:** any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- **Registered outputs:** all outputs come directly from flops, with no combinational path from `btn_raw`.

## Configuration
- **`BTN_REPEAT_EN` defined:** the repeat timer is built and `repeat_pulse` operates as described.
- **`BTN_REPEAT_EN` undefined:** the timer is removed, `repeat_pulse` is tied to 0 and `count_pulse` equals `press_pulse`. The REPEAT_* parameters are then ignored.

## Structure
- **Package `btn_pkg`:**
  - FSM state enum `btn_state_t` (IDLE, PRESS_WAIT, HELD, REL_WAIT).
  - Default constants `BTN_DEBOUNCE_DEFAULT`, `BTN_REPEAT_DELAY_DEFAULT`, `BTN_REPEAT_RATE_DEFAULT`.
- **Sub-module `btn_sync`:** parameterized synchronizer chain with asynchronous reset to 0. It is reused for the counter's reset button.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- **Clean press:** `btn_raw` goes 0→1 and is held 20 cycles → `press_pulse` is high for 1 cycle exactly 6 edges after the transition; `btn_level`=1; no other pulses (macro off).
- **Bounce:** `btn_raw` toggles 1,0,1,0 each cycle, then stays 1 → no pulse during toggling; exactly one `press_pulse` 6 edges after the final rise.
- **Release with bounce:** starting from HELD, `btn_raw` goes 0 for 2 cycles, 1 for 1 cycle, then 0 → one `release_pulse` 6 edges after the final fall; `btn_level`=0.
- **Repeat (BTN_REPEAT_EN):** hold for 25 cycles after `press_pulse` → `repeat_pulse` at +10, +13, +16, +19, +22, +25; `count_pulse` totals 7 pulses.
- **Reset mid-hold:** assert `rst` while in HELD → all outputs 0 immediately. Release `rst` with the button still held → `press_pulse` 6 edges later.
- **ACTIVE_LOW=1:** drive `btn_raw` 1→0 → `press_pulse` after 6 edges; drive it 0→1 → `release_pulse` after 6 edges.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEFAULT     = 500000;
    localparam int BTN_REPEAT_DELAY_DEFAULT = 25000000;
    localparam int BTN_REPEAT_RATE_DEFAULT  = 5000000;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Metastability synchronizer chain, STAGES flops deep, async reset to 0.
// Latency STAGES cycles; no backpressure.
module btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Raw button -> synchronized, debounced level plus press/release/repeat pulses; press and release
// appear SYNC_STAGES+DEBOUNCE_CYCLES edges after a stable input change; no backpressure. Auto-repeat built when BTN_REPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = BTN_REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic count_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    // Transition fires on the edge the counter would step to DEBOUNCE_CYCLES-1.
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 2);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("button_conditioner: illegal parameter value");
    end

    btn_state_t    state;
    logic [DW-1:0] db_cnt;
    logic          s;

    btn_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw ^ ACTIVE_LOW),
        .q   (s)
    );

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(btn_max(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_RATE - 1);
    logic [RW-1:0] rpt_cnt;
`else
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            count_pulse   <= 1'b0;
`ifdef BTN_REPEAT_EN
            rpt_cnt       <= '0;
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            count_pulse   <= 1'b0;
`ifdef BTN_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    db_cnt <= '0;
                    if (s) state <= PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        db_cnt      <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        count_pulse <= 1'b1;
`ifdef BTN_REPEAT_EN
                        rpt_cnt     <= RPT_FIRST;
`endif
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    db_cnt <= '0;
                    if (!s) begin
                        state <= REL_WAIT;
                    end
`ifdef BTN_REPEAT_EN
                    else if (rpt_cnt == '0) begin
                        repeat_pulse <= 1'b1;
                        count_pulse  <= 1'b1;
                        rpt_cnt      <= RPT_NEXT;
                    end else begin
                        rpt_cnt <= rpt_cnt - 1'b1;
                    end
`endif
                end
                REL_WAIT: begin
                    // Repeat timer is left untouched here so a release bounce resumes it.
                    if (s) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        db_cnt        <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed vector bench for button_conditioner (SYNC 2, DEBOUNCE 4, DELAY 10, RATE 3).
module tb_button_conditioner;

`ifdef BTN_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic raw, raw_al;
    logic level, press, rel, rpt, cnt;
    logic level_al, press_al, rel_al, rpt_al, cnt_al;

    always #5 clk = ~clk;

    button_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(raw),
        .btn_level(level), .press_pulse(press), .release_pulse(rel),
        .repeat_pulse(rpt), .count_pulse(cnt)
    );

    button_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut_al (
        .clk(clk), .rst(rst), .btn_raw(raw_al),
        .btn_level(level_al), .press_pulse(press_al), .release_pulse(rel_al),
        .repeat_pulse(rpt_al), .count_pulse(cnt_al)
    );

    // Output bundle order: {level, press, release, repeat, count}
    wire [4:0] o    = {level, press, rel, rpt, cnt};
    wire [4:0] o_al = {level_al, press_al, rel_al, rpt_al, cnt_al};

    typedef struct {
        logic       raw;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input bit r, input bit lvl, input bit prs, input bit rl, input bit rp);
        vec_t v;
        v.raw = r;
        v.exp = {lvl, prs, rl, rp, prs | rp};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    initial begin
        int total;
        bit exp_r;

        // Idle after reset
        for (int j = 0; j < 3; j++) tbl.push_back(mk(0, 0, 0, 0, 0));
        // Clean press, held; repeats at +10 and +13 when enabled
        for (int j = 0; j < 19; j++)
            tbl.push_back(mk(1, j >= 5, j == 5, 0, REP_ON && (j == 15 || j == 18)));
        // Clean release
        for (int j = 0; j < 8; j++) tbl.push_back(mk(0, j < 5, 0, j == 5, 0));
        // Bouncing press 1,0,1,0 then steady 1; final rise at j=4
        for (int j = 0; j < 13; j++)
            tbl.push_back(mk((j >= 4) || (j % 2 == 0), j >= 9, j == 9, 0, 0));
        // Bouncing release 0,0,1,0...; final fall at j=3
        for (int j = 0; j < 10; j++) tbl.push_back(mk(j == 2, j < 8, 0, j == 8, 0));
        // 3-cycle glitch: rejected
        for (int j = 0; j < 10; j++) tbl.push_back(mk(j < 3, 0, 0, 0, 0));
        // 4-cycle pulse: minimum accepted press, then release
        for (int j = 0; j < 12; j++)
            tbl.push_back(mk(j < 4, (j >= 5) && (j < 9), j == 5, j == 9, 0));

        rst = 1'b1;
        raw = 1'b0;
        raw_al = 1'b1;
        repeat (3) step();
        chk("reset_main", o, 5'b0);
        chk("reset_al", o_al, 5'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            raw = tbl[i].raw;
            step();
            chk($sformatf("vec%0d", i), o, tbl[i].exp);
        end

        // Hold-to-repeat
        raw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("rpt_pre%0d", k), o, 5'b0);
        end
        step();
        chk("rpt_press", o, 5'b11001);
        total = 1;
        for (int k = 1; k <= 25; k++) begin
            step();
            exp_r = REP_ON && (k >= 10) && ((k - 10) % 3 == 0);
            chk($sformatf("rpt_k%0d", k), {3'b0, rpt, cnt}, {3'b0, exp_r, exp_r});
            total += cnt;
        end
        chk("rpt_total", 5'(total), REP_ON ? 5'd7 : 5'd1);

        // Reset mid-hold, button still held through reset
        rst = 1'b1;
        #1;
        chk("rst_mid_hold", o, 5'b0);
        chk("rst_mid_hold_al", o_al, 5'b0);
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("rst_pre%0d", k), o, 5'b0);
        end
        step();
        chk("rst_press", o, 5'b11001);
        raw = 1'b0;
        repeat (12) step();
        chk("rst_released", o, 5'b0);

        // Active-low instance
        raw_al = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("al_pre%0d", k), o_al, 5'b0);
        end
        step();
        chk("al_press", o_al, 5'b11001);
        step();
        step();
        raw_al = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("al_rel_pre%0d", k), o_al, 5'b10000);
        end
        step();
        chk("al_release", o_al, 5'b00100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
